// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared encodings and types for the iterative mul/div unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Operation encodings presented on op
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Iteration counter width for the default 32-bit datapath
    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W         = $clog2(WIDTH_DEFAULT + 1);

    // Iteration counter width for an arbitrary datapath width
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_if
//  Description : Operand/command/result bundle between EX and the mul/div unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             hilo_use;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    // Pipeline side: issues commands, observes HI/LO and status
    modport master (
        output start, op, opA, opB, mthi, mtlo, wdata, hilo_use,
        input  hi, lo, busy, done, stall
    );

    // Unit side
    modport slave (
        input  start, op, opA, opB, mthi, mtlo, wdata, hilo_use,
        output hi, lo, busy, done, stall
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One radix-2 iteration: shift-add multiply or restoring divide.
//                Accumulator layout is {upper half, lower half}; for divide
//                the upper half is the partial remainder and the lower half
//                holds the remaining dividend bits with quotient bits shifted
//                in at the bottom (supplied separately as q_bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // Single iteration; divide leaves the LSB clear for the quotient bit
    always_comb begin
        w_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        w_shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        w_trial   = w_shifted - {1'b0, operand};
        q_bit     = 1'b0;
        acc_next  = {w_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            // Bit WIDTH set means the trial subtract borrowed: restore
            q_bit    = ~w_trial[WIDTH];
            acc_next = {(w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                        acc[WIDTH-2:0], 1'b0};
        end
    end
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative MULT/MULTU/DIV/DIVU with HI/LO registers. Signed
//                operations run on magnitudes and are sign-corrected in FIX.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam int                 c_cnt_w     = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_count;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_operand;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_is_div;
    logic                 r_neg_res;
    logic                 r_neg_rem;
    logic                 r_div_zero;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_signed;
    logic                 w_is_div;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [2*WIDTH-1:0]   w_step_acc;
    logic                 w_q_bit;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;

    // Operand decode: signed ops iterate on magnitudes
    always_comb begin
        w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        w_is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        w_abs_a  = (w_signed && bus.opA[WIDTH-1]) ? -bus.opA : bus.opA;
        w_abs_b  = (w_signed && bus.opB[WIDTH-1]) ? -bus.opB : bus.opB;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (r_is_div),
        .acc      (r_acc),
        .operand  (r_operand),
        .acc_next (w_step_acc),
        .q_bit    (w_q_bit)
    );

    // Sign correction of the finished magnitude result
    always_comb begin
        w_prod   = r_neg_res ? -r_acc : r_acc;
        w_quot   = r_acc[WIDTH-1:0];
        w_rem    = r_acc[2*WIDTH-1:WIDTH];
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            // Divide by zero yields all-ones quotient regardless of signs;
            // the remainder path already reproduces opA in that case.
            w_fix_lo = r_div_zero ? '1 : (r_neg_res ? -w_quot : w_quot);
            w_fix_hi = r_neg_rem ? -w_rem : w_rem;
        end
    end

    // Controller, iteration datapath and HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_acc      <= '0;
            r_operand  <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.mthi) r_hi <= bus.wdata;
                    if (bus.mtlo) r_lo <= bus.wdata;
                    if (bus.start) begin
                        r_state    <= RUN;
                        r_busy     <= 1'b1;
                        r_count    <= '0;
                        r_is_div   <= w_is_div;
                        r_neg_res  <= w_signed & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
                        r_neg_rem  <= w_signed & bus.opA[WIDTH-1];
                        r_div_zero <= (bus.opB == '0);
                        if (w_is_div) begin
                            r_acc     <= {{WIDTH{1'b0}}, w_abs_a};
                            r_operand <= w_abs_b;
                        end else begin
                            r_acc     <= {{WIDTH{1'b0}}, w_abs_b};
                            r_operand <= w_abs_a;
                        end
                    end
                end
                RUN: begin
                    r_acc <= {w_step_acc[2*WIDTH-1:1], (r_is_div ? w_q_bit : w_step_acc[0])};
                    if (r_count == c_last_iter) begin
                        r_count <= '0;
                        r_state <= FIX;
                        r_done  <= 1'b1;
                    end else begin
                        r_count <= r_count + c_cnt_w'(1);
                    end
                end
                FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.stall = r_busy & bus.hilo_use;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit: directed corner cases
//                plus randomized traffic compared against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic clk;
    logic reset;
    logic chk_en;
    int   checks;
    int   failures;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Architectural result {HI,LO} of one operation
    function automatic logic [63:0] ref_result(input logic [1:0] o,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            OP_MULT:  p = 64'(sa * sb);
            OP_MULTU: p = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a busy countdown plus the pending result
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi  <= '0;
            m_lo  <= '0;
            m_res <= '0;
            m_cnt <= 0;
        end else if (m_cnt == 0) begin
            if (bus.mthi) m_hi <= bus.wdata;
            if (bus.mtlo) m_lo <= bus.wdata;
            if (bus.start) begin
                m_cnt <= LAT;
                m_res <= ref_result(bus.op, bus.opA, bus.opB);
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_hi <= m_res[63:32];
                m_lo <= m_res[31:0];
            end
        end
    end

    // Cycle-by-cycle compare of every output against the model
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("cyc_busy",  bus.busy,  64'(m_cnt != 0));
            chk("cyc_done",  bus.done,  64'(m_cnt == 1));
            chk("cyc_stall", bus.stall, 64'((m_cnt != 0) && bus.hilo_use));
            chk("cyc_hi",    bus.hi,    m_hi);
            chk("cyc_lo",    bus.lo,    m_lo);
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = o; bus.opA = a; bus.opB = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Cycle index (1 = first cycle after the start edge) of the done pulse
    task automatic wait_done(output int k);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int k;
        issue(o, a, b);
        wait_done(k);
        chk({name, "_done_cycle"}, 64'(k), 64'(LAT));
        @(negedge clk);
        chk({name, "_busy_after"}, bus.busy, 64'd0);
        chk({name, "_hi"}, bus.hi, eh);
        chk({name, "_lo"}, bus.lo, el);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          k;
        int          sc;
        logic [31:0] lo_before;
        checks   = 0;
        failures = 0;
        chk_en   = 1'b0;
        reset    = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.opA = '0; bus.opB = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0; bus.hilo_use = 1'b1;
        #2 reset = 1'b1;
        #20 reset = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_hi",    bus.hi,    64'd0);
        chk("rst_lo",    bus.lo,    64'd0);
        chk("rst_busy",  bus.busy,  64'd0);
        chk("rst_done",  bus.done,  64'd0);
        chk("rst_stall", bus.stall, 64'd0);
        bus.hilo_use = 1'b0;

        // Directed arithmetic corners
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", OP_DIVU,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div_zero",  OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // Stall window and ignored MTLO during RUN
        issue(OP_MULT, 32'hFFFF_FFFE, 32'h0001_2345);
        bus.hilo_use = 1'b1;
        sc = 0;
        lo_before = '0;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            if (bus.stall) sc++;
            if (i == 5) begin
                lo_before = bus.lo;
                bus.mtlo = 1'b1;
                bus.wdata = 32'hDEAD_BEEF;
            end
            if (i == 6) bus.mtlo = 1'b0;
            if (i == 7)  chk("run_mtlo_ignored", bus.lo, lo_before);
            if (i == 33) chk("stall_done_pulse", bus.done, 64'd1);
            if (i == 34) chk("stall_release", bus.stall, 64'd0);
        end
        chk("stall_cycles", 64'(sc), 64'(LAT));
        chk("stall_hi", bus.hi, 32'hFFFF_FFFF);
        chk("stall_lo", bus.lo, 32'hFFFD_B976);
        bus.hilo_use = 1'b0;

        // MTHI in IDLE, then MTHI together with start
        lo_before = bus.lo;
        @(posedge clk); #1;
        bus.mthi = 1'b1; bus.wdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        @(negedge clk);
        chk("mthi_hi", bus.hi, 32'h1234_5678);
        chk("mthi_lo_kept", bus.lo, lo_before);
        @(posedge clk); #1;
        bus.mthi = 1'b1; bus.wdata = 32'hAAAA_5555;
        bus.start = 1'b1; bus.op = OP_MULTU; bus.opA = 32'h0001_2345; bus.opB = 32'h0001_0000;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        chk("mthi_start_hi", bus.hi, 32'hAAAA_5555);
        chk("mthi_start_busy", bus.busy, 64'd1);
        wait_done(k);
        chk("mthi_start_done_cycle", 64'(k + 1), 64'(LAT));
        @(negedge clk);
        chk("mthi_start_res_hi", bus.hi, 32'h0000_0001);
        chk("mthi_start_res_lo", bus.lo, 32'h2345_0000);

        // Asynchronous reset in cycle N+10 of a DIV
        bus.hilo_use = 1'b1;
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #2;
        chk("mid_busy_pre", bus.busy, 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy",  bus.busy,  64'd0);
        chk("mid_rst_stall", bus.stall, 64'd0);
        chk("mid_rst_done",  bus.done,  64'd0);
        chk("mid_rst_hi",    bus.hi,    64'd0);
        chk("mid_rst_lo",    bus.lo,    64'd0);
        #1 reset = 1'b0;
        bus.hilo_use = 1'b0;
        run_op("post_rst_divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // Randomized traffic, including back-to-back starts
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.op       = 2'($urandom_range(0, 3));
            bus.opA      = pick();
            bus.opB      = pick();
            bus.mthi     = ($urandom_range(0, 7) == 0);
            bus.mtlo     = ($urandom_range(0, 7) == 0);
            bus.wdata    = $urandom;
            bus.hilo_use = ($urandom_range(0, 1) == 1);
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        for (int i = 0; i < 40 && m_cnt != 0; i++) @(posedge clk);
        chk("drain_idle", 64'(m_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
